// File: rtl/watermark_blend_engine_if.sv
// rtl/watermark_blend_engine_if.sv - APB register/buffer port bundle for watermark_blend_engine
interface watermark_blend_engine_if #(
  parameter int amba_word       = 16,
  parameter int amba_addr_depth = 20
);
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [amba_addr_depth-1:0] PADDR;
  logic [amba_word-1:0]       PWDATA;
  logic [amba_word-1:0]       PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

// File: rtl/watermark_blend_engine.sv
// rtl/watermark_blend_engine.sv - APB-loaded multi-channel alpha watermark blender
// Optional macro WM_KEY_COLOR_EN adds a KEY register that passes image samples through on key match.
module watermark_blend_engine #(
  parameter int Data_Depth      = 8,
  parameter int amba_word       = 16,
  parameter int amba_addr_depth = 20,
  parameter int Num_Channels    = 3,
  parameter int Img_Depth       = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  watermark_blend_engine_if.slave            apb,
  output logic [Num_Channels*Data_Depth-1:0] Pixel_Data,
  output logic                               new_pixel,
  output logic                               Image_Done
);
  localparam int D     = Data_Depth;
  localparam int NC    = Num_Channels;
  localparam int DEPTH = Img_Depth * NC;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = $clog2(Img_Depth + 1);
  localparam int CW    = (NC > 1) ? $clog2(NC) : 1;
  localparam int AW    = amba_addr_depth;
  localparam int OW    = AW - 2;
  localparam int SW    = 2 * D + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [OW-1:0]        DEPTH_A     = OW'(DEPTH);
  localparam logic [amba_word-1:0] ALPHA_MAX_W = amba_word'(1 << D);
  localparam logic [amba_word-1:0] PIX_MAX_W   = amba_word'(Img_Depth);
  localparam logic [D:0]           ALPHA_ONE   = (D+1)'(1 << D);
  localparam logic [PW-1:0]        PIX_MAX     = PW'(Img_Depth);
  localparam logic [CW-1:0]        CH_LAST     = CW'(NC - 1);

  logic [2:0]           state;
  logic [CW-1:0]        ch, rd_ch;
  logic [PW-1:0]        pix;
  logic [IW-1:0]        rd_idx;
  logic                 rd_valid;
  logic [D:0]           alpha_r, alpha_s, inv_alpha;
  logic [PW-1:0]        cnt_r, cnt_s;
  logic                 done_f, err_f;
  logic [NC*D-1:0]      shadow, next_shadow;
  logic [D-1:0]         img_mem [DEPTH];
  logic [D-1:0]         wm_mem  [DEPTH];
  logic [D-1:0]         img_q, wm_q, blend;
  logic [SW-1:0]        sum;
  logic                 sum_unused;
  logic [1:0]           region;
  logic [OW-1:0]        offset;
  logic                 wr, rd_setup, busy, reg_hit, buf_hit, start_req, last_pix;
  logic [amba_word-1:0] rd_val;
`ifdef WM_KEY_COLOR_EN
  logic [D-1:0]         key_r, key_s;
`endif

  assign region    = apb.PADDR[AW-1:AW-2];
  assign offset    = apb.PADDR[OW-1:0];
  assign wr        = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_setup  = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign busy      = (state == S_FETCH) || (state == S_CALC) || (state == S_EMIT);
  assign reg_hit   = wr && (region == 2'b00);
  assign buf_hit   = wr && ((region == 2'b01) || (region == 2'b10));
  assign start_req = reg_hit && (offset == OW'(0)) && apb.PWDATA[0] && !busy;
  assign last_pix  = (pix == cnt_s - PW'(1));

  // Sample buffers are plain RAM: no reset, one-cycle registered read.
  always_ff @(posedge clk) begin
    if (buf_hit && !busy && (offset < DEPTH_A)) begin
      if (region == 2'b01)
        img_mem[offset[IW-1:0]] <= apb.PWDATA[D-1:0];
      else
        wm_mem[offset[IW-1:0]] <= apb.PWDATA[D-1:0];
    end
    img_q <= img_mem[rd_idx];
    wm_q  <= wm_mem[rd_idx];
  end

  assign inv_alpha  = ALPHA_ONE - alpha_s;
  assign sum        = SW'(alpha_s) * SW'(wm_q) + SW'(inv_alpha) * SW'(img_q) + SW'(1 << (D - 1));
  assign sum_unused = ^{sum[SW-1:2*D], sum[D-1:0]};

  always_comb begin
    blend = sum[2*D-1:D];
`ifdef WM_KEY_COLOR_EN
    if (wm_q == key_s)
      blend = img_q;
`endif
  end

  always_comb begin
    next_shadow = shadow;
    if (rd_valid)
      next_shadow[rd_ch*D +: D] = blend;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alpha_r <= '0;
      cnt_r   <= PIX_MAX;
`ifdef WM_KEY_COLOR_EN
      key_r   <= '0;
`endif
    end else if (reg_hit) begin
      if (offset == OW'(1))
        alpha_r <= (apb.PWDATA > ALPHA_MAX_W) ? ALPHA_ONE : (D+1)'(apb.PWDATA);
      if (offset == OW'(2))
        cnt_r <= ((apb.PWDATA == '0) || (apb.PWDATA > PIX_MAX_W)) ? PIX_MAX : PW'(apb.PWDATA);
`ifdef WM_KEY_COLOR_EN
      if (offset == OW'(4))
        key_r <= apb.PWDATA[D-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      rd_ch      <= '0;
      pix        <= '0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      alpha_s    <= '0;
      cnt_s      <= PIX_MAX;
      done_f     <= 1'b0;
      err_f      <= 1'b0;
      shadow     <= '0;
      Pixel_Data <= '0;
      new_pixel  <= 1'b0;
      Image_Done <= 1'b0;
`ifdef WM_KEY_COLOR_EN
      key_s      <= '0;
`endif
    end else begin
      new_pixel  <= 1'b0;
      Image_Done <= 1'b0;
      rd_valid   <= (state == S_FETCH);
      rd_ch      <= ch;
      shadow     <= next_shadow;
      if (buf_hit && busy)
        err_f <= 1'b1;
      case (state)
        S_FETCH: begin
          rd_idx <= rd_idx + IW'(1);
          if (ch == CH_LAST) begin
            ch    <= '0;
            state <= S_CALC;
          end else begin
            ch <= ch + CW'(1);
          end
        end
        S_CALC: begin
          // Last channel's read lands this cycle, so publish the merged shadow.
          Pixel_Data <= next_shadow;
          new_pixel  <= 1'b1;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (last_pix) begin
            Image_Done <= 1'b1;
            done_f     <= 1'b1;
            state      <= S_DONE;
          end else begin
            pix   <= pix + PW'(1);
            state <= S_FETCH;
          end
        end
        default: begin
          if (start_req) begin
            state   <= S_FETCH;
            ch      <= '0;
            pix     <= '0;
            rd_idx  <= '0;
            alpha_s <= alpha_r;
            cnt_s   <= cnt_r;
            done_f  <= 1'b0;
            err_f   <= 1'b0;
`ifdef WM_KEY_COLOR_EN
            key_s   <= key_r;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    if (region == 2'b00) begin
      case (offset)
        OW'(1): rd_val = amba_word'(alpha_r);
        OW'(2): rd_val = amba_word'(cnt_r);
        OW'(3): rd_val = amba_word'({err_f, done_f, busy});
`ifdef WM_KEY_COLOR_EN
        OW'(4): rd_val = amba_word'(key_r);
`endif
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      apb.PRDATA <= '0;
    else if (rd_setup)
      apb.PRDATA <= rd_val;
  end
endmodule

// File: tb/tb_watermark_blend_engine.sv
// tb/tb_watermark_blend_engine.sv - self-checking bench for watermark_blend_engine
module tb_watermark_blend_engine;
`ifdef WM_KEY_COLOR_EN
  localparam bit KEY_ON = 1'b1;
`else
  localparam bit KEY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] Pixel_Data;
  logic        new_pixel;
  logic        Image_Done;

  watermark_blend_engine_if #(.amba_word(16), .amba_addr_depth(20)) apb ();

  watermark_blend_engine #(
    .Data_Depth(8), .amba_word(16), .amba_addr_depth(20), .Num_Channels(3), .Img_Depth(256)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .Pixel_Data(Pixel_Data), .new_pixel(new_pixel), .Image_Done(Image_Done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  img_m [768];
  logic [7:0]  wm_m  [768];
  logic [7:0]  key_m = 8'h00;
  logic [23:0] px_q [$];
  int          pc_q [$];
  bit          done_seen = 1'b0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          last_wr_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (new_pixel) begin
        px_q.push_back(Pixel_Data);
        pc_q.push_back(cyc);
      end
      if (Image_Done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] a_reg(input int o);
    return {2'b00, 18'(o)};
  endfunction
  function automatic logic [19:0] a_img(input int i);
    return {2'b01, 18'(i)};
  endfunction
  function automatic logic [19:0] a_wm(input int i);
    return {2'b10, 18'(i)};
  endfunction

  // Reference: blend from the arithmetic definition over the bench's own copy of the buffers.
  function automatic logic [23:0] exp_px(input int p, input int a);
    logic [23:0] r;
    int i, w, v;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      i = int'(img_m[p*3+c]);
      w = int'(wm_m[p*3+c]);
      v = (a * w + (256 - a) * i + 128) / 256;
      if (KEY_ON && (w == int'(key_m)))
        v = i;
      r[c*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic apb_write(input logic [19:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic apb_read(input logic [19:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    d = apb.PRDATA;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic set_sample(input int p, input int c, input logic [7:0] iv, input logic [7:0] wv);
    img_m[p*3+c] = iv;
    wm_m[p*3+c]  = wv;
    apb_write(a_img(p*3+c), {8'h00, iv});
    apb_write(a_wm(p*3+c), {8'h00, wv});
  endtask

  task automatic start_frame(input int a, input int n);
    apb_write(a_reg(1), 16'(a));
    apb_write(a_reg(2), 16'(n));
    px_q.delete();
    pc_q.delete();
    done_seen = 1'b0;
    apb_write(a_reg(0), 16'h0001);
    start_cyc = last_wr_cyc;
  endtask

  task automatic finish_frame(input string tag, input int a, input int n, input int status);
    int t;
    logic [15:0] rd;
    t = 0;
    while (!done_seen && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, 64'(px_q.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_px%0d", tag, k), (k < px_q.size()) ? 64'(px_q[k]) : 64'hx, 64'(exp_px(k, a)));
      check($sformatf("%s_t%0d", tag, k), (k < pc_q.size()) ? 64'(pc_q[k] - start_cyc) : 64'hx,
            64'(4 + 5 * k));
    end
    check({tag, "_done_t"}, 64'(done_cyc - start_cyc), 64'(5 * n));
    check({tag, "_hold"}, 64'(Pixel_Data), 64'(exp_px(n - 1, a)));
    apb_read(a_reg(3), rd);
    check({tag, "_status"}, 64'(rd), 64'(status));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int a, t;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;

    #2 rst = 1'b0;
    #1;
    check("rst_pixel", 64'(Pixel_Data), 64'd0);
    check("rst_new_pixel", 64'(new_pixel), 64'd0);
    check("rst_image_done", 64'(Image_Done), 64'd0);
    check("rst_prdata", 64'(apb.PRDATA), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    apb_read(a_reg(3), rd); check("rst_status", 64'(rd), 64'd0);
    apb_read(a_reg(1), rd); check("rst_alpha", 64'(rd), 64'd0);
    apb_read(a_reg(2), rd); check("rst_pix_cnt", 64'(rd), 64'd256);
    apb_read(a_reg(4), rd); check("rst_key", 64'(rd), 64'd0);

    for (int c = 0; c < 3; c++) set_sample(0, c, 8'd200, 8'd100);
    start_frame(128, 1);
    finish_frame("directed", 128, 1, 2);
    check("directed_literal", (px_q.size() > 0) ? 64'(px_q[0]) : 64'hx, 64'h969696);

    apb_write(a_reg(1), 16'd300); apb_read(a_reg(1), rd); check("alpha_sat300", 64'(rd), 64'd256);
    apb_write(a_reg(1), 16'd256); apb_read(a_reg(1), rd); check("alpha_256", 64'(rd), 64'd256);
    apb_write(a_reg(1), 16'd255); apb_read(a_reg(1), rd); check("alpha_255", 64'(rd), 64'd255);
    apb_write(a_reg(2), 16'd0);   apb_read(a_reg(2), rd); check("cnt_zero", 64'(rd), 64'd256);
    apb_write(a_reg(2), 16'd300); apb_read(a_reg(2), rd); check("cnt_big", 64'(rd), 64'd256);
    apb_write(a_reg(2), 16'd7);   apb_read(a_reg(2), rd); check("cnt_7", 64'(rd), 64'd7);
    apb_read(a_img(0), rd); check("buf_read_zero", 64'(rd), 64'd0);

    for (int p = 0; p < 16; p++)
      for (int c = 0; c < 3; c++)
        set_sample(p, c, 8'($urandom), 8'($urandom));

    start_frame(0, 16);
    finish_frame("alpha0", 0, 16, 2);
    start_frame(256, 16);
    finish_frame("alpha256", 256, 16, 2);
    a = int'($urandom_range(1, 255));
    start_frame(a, 16);
    finish_frame("alpha_rand", a, 16, 2);

    a = int'($urandom_range(1, 255));
    start_frame(a, 4);
    apb_write(a_img(0), {8'h00, ~img_m[0]});
    apb_write(a_reg(0), 16'h0001);
    apb_write(a_reg(1), 16'd0);
    finish_frame("err", a, 4, 6);
    start_frame(a, 1);
    apb_read(a_reg(3), rd);
    check("err_cleared_busy", 64'(rd), 64'd1);
    finish_frame("clr", a, 1, 2);

    a = int'($urandom_range(1, 255));
    start_frame(a, 10);
    t = 0;
    while (px_q.size() < 3 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_reach", 64'(px_q.size()), 64'd3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_new_pixel", 64'(new_pixel), 64'd0);
    check("rst_mid_image_done", 64'(Image_Done), 64'd0);
    check("rst_mid_pixel", 64'(Pixel_Data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_mid_no_done", 64'(done_seen), 64'd0);
    check("rst_mid_no_more_px", 64'(px_q.size()), 64'd3);
    apb_read(a_reg(3), rd); check("rst_mid_status", 64'(rd), 64'd0);
    apb_read(a_reg(1), rd); check("rst_mid_alpha", 64'(rd), 64'd0);
    apb_read(a_reg(2), rd); check("rst_mid_cnt", 64'(rd), 64'd256);
    start_frame(a, 10);
    finish_frame("post_rst", a, 10, 2);

    apb_write(a_reg(4), 16'h00FF);
    apb_read(a_reg(4), rd);
`ifdef WM_KEY_COLOR_EN
    check("key_read", 64'(rd), 64'hFF);
    key_m = 8'hFF;
    set_sample(0, 0, 8'd10, 8'hFF);
    set_sample(0, 1, 8'd20, 8'h00);
    set_sample(0, 2, 8'd30, 8'hFF);
    start_frame(256, 1);
    finish_frame("key", 256, 1, 2);
    check("key_literal", (px_q.size() > 0) ? 64'(px_q[0]) : 64'hx, 64'h1E000A);
`else
    check("key_absent", 64'(rd), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/watermark_blend_engine.md
# watermark_blend_engine

APB-programmed, multi-channel visible-watermark blending engine that generalises the single-channel Visible_Watermarking block. Image and watermark samples are loaded over APB into internal buffers. On start, every pixel is alpha-blended channel by channel. Each result pixel is presented as one packed word with a `new_pixel` strobe, and `Image_Done` is pulsed at the end of the frame.

## Interface
- Data_Depth, 8, bits per channel sample (D); must be ≤ amba_word.
- amba_word, 16, APB data width.
- amba_addr_depth, 20, APB address width.
- Num_Channels, 3, channels per pixel (NC), 1..4.
- Img_Depth, 256, maximum pixels per frame; each buffer holds Img_Depth*NC samples.
- clk  in  1  clock; single clock domain, all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  amba_addr_depth  APB address.
- PWDATA  in  amba_word  APB write data.
- PRDATA  out  amba_word  APB read data.
- Pixel_Data  out  NC*D  blended pixel; channel c occupies bits [c*D +: D].
- new_pixel  out  1  one-cycle strobe qualifying Pixel_Data.
- Image_Done  out  1  one-cycle pulse at end of frame.

## Operation
- APB transfers are zero-wait-state. A write commits on PSEL&PENABLE&PWRITE.
- Region select is PADDR[top:top-1].
  - 00 selects registers.
  - 01 selects the image buffer.
  - 10 selects the watermark buffer.
  - 11 is ignored.
- Buffer index is PADDR[low bits] = pixel*NC + channel. The write stores PWDATA[D-1:0].
- Register map (word offsets):
  - 0 CTRL: a write of bit0=1 means start.
  - 1 ALPHA: D+1 bits. A write greater than 2^D saturates to 2^D.
  - 2 PIX_CNT: pixels to process, 1..Img_Depth. A write of 0 or a value greater than Img_Depth is clamped to Img_Depth.
  - 3 STATUS: read-only. bit0 busy, bit1 done (sticky), bit2 err (sticky).
  - 4 KEY: macro only.
- Reads return the register value zero-extended. Reads of the buffer regions return 0.
- FSM states and transitions:
  - IDLE → FETCH on a start write.
  - FETCH runs NC cycles, reading channel c of both buffers in cycle c.
  - FETCH → CALC. CALC absorbs the last read's latency while channels accumulate in the output shadow.
  - CALC → EMIT. EMIT drives new_pixel=1.
  - EMIT → FETCH of the next pixel, or → DONE after pixel PIX_CNT-1.
  - DONE pulses Image_Done, sets done, → IDLE.
- ALPHA and PIX_CNT are latched into shadows at start. Register writes during busy update the register but not the running frame.
- Start while busy is ignored. A buffer write while busy is dropped and sets err.
- A start write clears done and err.
- Blend per channel: out = (α·wm + (2^D−α)·img + 2^(D−1)) >> D.
  - Products are 2D+1 bits and the sum is 2D+2 bits.
  - The result always fits in D bits, so no saturation logic is needed.
  - α=0 gives img exactly. α=2^D gives wm exactly.

## Timing
- Reset values: PRDATA=0, Pixel_Data=0, new_pixel=0, Image_Done=0, ALPHA=0, PIX_CNT=Img_Depth, STATUS=0, FSM=IDLE.
- Buffer contents are not reset.
- The first FETCH cycle is the cycle after the start write's access phase.
- Pixel period is NC+2 cycles. There is no overlap between pixels.
- Pixel k's new_pixel is asserted at cycle NC+1+k·(NC+2) after the first FETCH cycle.
- Image_Done rises the cycle after the last new_pixel. busy falls in that same cycle.
- Pixel_Data holds its value between strobes.
- PRDATA is registered on the setup-phase edge and is valid during the access phase.
- Reset asserted mid-frame returns all outputs to their reset values asynchronously. No Image_Done is produced.
- The shortest frame (PIX_CNT=1) takes NC+3 cycles from the first FETCH to Image_Done.

## Configuration
- WM_KEY_COLOR_EN
  - Defined:
    - Register 4 KEY (D bits, reset 0) exists.
    - Any channel whose watermark sample equals the latched KEY outputs the image sample unchanged, regardless of α.
    - KEY is latched at start.
  - Undefined:
    - Register 4 reads 0 and writes are ignored.
    - All channels blend normally.

## Test plan
- D=8, NC=3, α=128, img=(200,200,200), wm=(100,100,100), PIX_CNT=1 → one new_pixel at cycle 4 with every channel 150; Image_Done at cycle 5.
- α=0, then α=256 → output equals img, then wm, bit-exact over 16 random pixels.
- Write ALPHA=300 → read back 256. Write PIX_CNT=0 → read back Img_Depth.
- Mid-frame buffer write plus second start → frame unaffected, STATUS.err=1; the next start clears err.
- Assert rst during pixel 3 of 10 → new_pixel and Image_Done stay 0, STATUS=0. A later full frame completes correctly.
- With WM_KEY_COLOR_EN, KEY=0xFF, wm=(0xFF,0,0xFF), img=(10,20,30), α=256 → output (10,0,30).
